// File: rtl/up_gpio.sv
// rtl/up_gpio.sv - single-channel GPIO with a req/ack register bus and an input-change interrupt
module up_gpio #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BUS_WIDTH     = 4,
  parameter int GPIO_WIDTH    = 32,
  parameter int IRQ_ENABLE    = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     up_rreq,
  output logic                     up_rack,
  input  logic [ADDRESS_WIDTH-1:0] up_raddr,
  output logic [BUS_WIDTH*8-1:0]   up_rdata,
  input  logic                     up_wreq,
  output logic                     up_wack,
  input  logic [ADDRESS_WIDTH-1:0] up_waddr,
  input  logic [BUS_WIDTH*8-1:0]   up_wdata,
  output logic                     irq,
  input  logic [GPIO_WIDTH-1:0]    gpio_io_i,
  output logic [GPIO_WIDTH-1:0]    gpio_io_o,
  output logic [GPIO_WIDTH-1:0]    gpio_io_t
);

  localparam int DW = BUS_WIDTH * 8;

  localparam logic [9:0] A_DATA = 10'h000;
  localparam logic [9:0] A_TRI  = 10'h001;
  localparam logic [9:0] A_GIER = 10'h047;
  localparam logic [9:0] A_ISR  = 10'h048;
  localparam logic [9:0] A_IER  = 10'h04A;

  logic [9:0]            ra;
  logic [9:0]            wa;
  logic [31:0]           wd;
  logic [31:0]           rd_word;
  logic                  rack_r;
  logic                  wack_r;
  logic [DW-1:0]         rdata_r;
  logic [GPIO_WIDTH-1:0] tri_r;
  logic [GPIO_WIDTH-1:0] out_r;
  logic [GPIO_WIDTH-1:0] in_s;
  logic [GPIO_WIDTH-1:0] in_d;
  logic [GPIO_WIDTH-1:0] data_rd;
  logic                  edge_any;
  logic                  gier;
  logic                  ier;
  logic                  isr;
  logic                  unused_bits;

  assign ra       = up_raddr[11:2];
  assign wa       = up_waddr[11:2];
  assign wd       = 32'(up_wdata);
  assign data_rd  = (in_s & tri_r) | (out_r & ~tri_r);
  assign edge_any = |((in_s ^ in_d) & tri_r);

  assign up_rack   = rack_r;
  assign up_wack   = wack_r;
  assign up_rdata  = rdata_r;
  assign gpio_io_o = out_r;
  assign gpio_io_t = tri_r;

  // Interrupt bits are tied off when IRQ_ENABLE=0, so they fall out of decode as zero.
  always_comb begin
    rd_word = '0;
    case (ra)
      A_DATA:  rd_word = 32'(data_rd);
      A_TRI:   rd_word = 32'(tri_r);
      A_GIER:  rd_word = {gier, 31'b0};
      A_ISR:   rd_word = {31'b0, isr};
      A_IER:   rd_word = {31'b0, ier};
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rack_r  <= 1'b0;
      wack_r  <= 1'b0;
      rdata_r <= '0;
      tri_r   <= '1;
      out_r   <= '0;
      in_s    <= gpio_io_i;
      in_d    <= gpio_io_i;
    end else begin
      rack_r  <= up_rreq;
      wack_r  <= up_wreq;
      rdata_r <= up_rreq ? DW'(rd_word) : '0;
      in_s    <= gpio_io_i;
      in_d    <= in_s;
      if (up_wreq && (wa == A_DATA)) out_r <= GPIO_WIDTH'(wd);
      if (up_wreq && (wa == A_TRI))  tri_r <= GPIO_WIDTH'(wd);
    end
  end

  generate
    if (IRQ_ENABLE != 0) begin : g_irq
      logic gier_r;
      logic ier_r;
      logic isr_r;
      logic irq_r;
      logic isr_clr;

      assign isr_clr = up_wreq && (wa == A_ISR) && wd[0];

      // A fresh edge in the same cycle as a clear keeps the status set.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          gier_r <= 1'b0;
          ier_r  <= 1'b0;
          isr_r  <= 1'b0;
          irq_r  <= 1'b0;
        end else begin
          if (up_wreq && (wa == A_GIER)) gier_r <= wd[31];
          if (up_wreq && (wa == A_IER))  ier_r  <= wd[0];
          isr_r <= (isr_r & ~isr_clr) | edge_any;
          irq_r <= gier_r & ier_r & isr_r;
        end
      end

      assign gier = gier_r;
      assign ier  = ier_r;
      assign isr  = isr_r;
      assign irq  = irq_r;
    end else begin : g_no_irq
      assign gier = 1'b0;
      assign ier  = 1'b0;
      assign isr  = 1'b0;
      assign irq  = 1'b0;
    end
  endgenerate

  assign unused_bits = ^{up_raddr, up_waddr, up_wdata, wd, edge_any};

endmodule

// File: tb/tb_up_gpio.sv
// tb/tb_up_gpio.sv - scoreboard bench for up_gpio
module tb_up_gpio;

  logic        clk = 1'b0;
  logic        rstn;
  logic        up_rreq;
  logic        up_rack;
  logic [31:0] up_raddr;
  logic [31:0] up_rdata;
  logic        up_wreq;
  logic        up_wack;
  logic [31:0] up_waddr;
  logic [31:0] up_wdata;
  logic        irq;
  logic [31:0] gpio_io_i;
  logic [31:0] gpio_io_o;
  logic [31:0] gpio_io_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rd_q[$];

  logic [31:0] tri_m, out_m, in_s_m, in_d_m;
  logic        gier_m, ier_m, isr_m, irq_m;

  up_gpio #(
    .ADDRESS_WIDTH(32),
    .BUS_WIDTH(4),
    .GPIO_WIDTH(32),
    .IRQ_ENABLE(1)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .up_rreq(up_rreq),
    .up_rack(up_rack),
    .up_raddr(up_raddr),
    .up_rdata(up_rdata),
    .up_wreq(up_wreq),
    .up_wack(up_wack),
    .up_waddr(up_waddr),
    .up_wdata(up_wdata),
    .irq(irq),
    .gpio_io_i(gpio_io_i),
    .gpio_io_o(gpio_io_o),
    .gpio_io_t(gpio_io_t)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a[11:2])
      10'h000: return (in_s_m & tri_m) | (out_m & ~tri_m);
      10'h001: return tri_m;
      10'h047: return {gier_m, 31'b0};
      10'h048: return {31'b0, isr_m};
      10'h04A: return {31'b0, ier_m};
      default: return 32'h0;
    endcase
  endfunction

  // One clock: queue read expectations, advance the model, then check every output.
  task automatic step();
    logic        p_rst, p_wr, p_rd, p_edge, p_clr;
    logic [31:0] p_wa, p_wd, p_in;
    p_rst = rstn;
    p_rd  = up_rreq;
    p_wr  = up_wreq;
    p_wa  = up_waddr;
    p_wd  = up_wdata;
    p_in  = gpio_io_i;
    if (p_rst && p_rd) rd_q.push_back(model_read(up_raddr));
    @(posedge clk);
    if (!p_rst) begin
      tri_m = '1; out_m = '0; in_s_m = p_in; in_d_m = p_in;
      gier_m = 0; ier_m = 0; isr_m = 0; irq_m = 0;
    end else begin
      p_edge = |((in_s_m ^ in_d_m) & tri_m);
      p_clr  = p_wr && (p_wa[11:2] == 10'h048) && p_wd[0];
      irq_m  = gier_m & ier_m & isr_m;
      isr_m  = (isr_m & ~p_clr) | p_edge;
      in_d_m = in_s_m;
      in_s_m = p_in;
      if (p_wr) begin
        case (p_wa[11:2])
          10'h000: out_m  = p_wd;
          10'h001: tri_m  = p_wd;
          10'h047: gier_m = p_wd[31];
          10'h04A: ier_m  = p_wd[0];
          default: ;
        endcase
      end
    end
    #1;
    check("rack", {31'b0, up_rack}, {31'b0, p_rst & p_rd});
    check("wack", {31'b0, up_wack}, {31'b0, p_rst & p_wr});
    if (up_rack) begin
      if (rd_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
      else check("rdata", up_rdata, rd_q.pop_front());
    end else begin
      check("rdata_idle", up_rdata, 32'h0);
    end
    check("gpio_t", gpio_io_t, tri_m);
    check("gpio_o", gpio_io_o, out_m);
    check("irq", {31'b0, irq}, {31'b0, irq_m});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    up_wreq = 1; up_waddr = a; up_wdata = d;
    step();
    up_wreq = 0;
  endtask

  task automatic rd(input logic [31:0] a);
    up_rreq = 1; up_raddr = a;
    step();
    up_rreq = 0;
  endtask

  initial begin
    rstn = 0; up_rreq = 1; up_wreq = 1; up_raddr = 0; up_waddr = 0;
    up_wdata = 32'hFFFF_FFFF; gpio_io_i = 32'h1234_5678;
    tri_m = '1; out_m = '0; in_s_m = '0; in_d_m = '0;
    gier_m = 0; ier_m = 0; isr_m = 0; irq_m = 0;
    repeat (3) step();
    check("rst_t", gpio_io_t, 32'hFFFF_FFFF);
    check("rst_o", gpio_io_o, 32'h0);
    rstn = 1; up_rreq = 0; up_wreq = 0;
    step();
    check("rst_drop", {30'b0, up_rack, up_wack}, 32'h0);

    // all inputs
    gpio_io_i = 32'hDEAD_BEEF;
    wr(32'h000, 32'hFFFF_FFFF);
    step();
    up_rreq = 1; up_raddr = 32'h000;
    repeat (4) step();
    up_rreq = 0;
    check("r024_data", up_rdata, 32'hDEAD_BEEF);
    check("r024_t", gpio_io_t, 32'hFFFF_FFFF);
    wr(32'h004, 32'hFFFF_FFFF);

    // all outputs
    wr(32'h004, 32'h0);
    wr(32'h000, 32'hBABE_DEAD);
    check("r025_t", gpio_io_t, 32'h0);
    check("r025_o", gpio_io_o, 32'hBABE_DEAD);
    rd(32'h000);
    check("r025_rd", up_rdata, 32'hBABE_DEAD);

    // mixed direction, plus read and write in the same cycle
    wr(32'h004, 32'h0000_FFFF);
    rd(32'h000);
    check("r026_rd", up_rdata, 32'hBABE_BEEF);
    up_rreq = 1; up_raddr = 32'h000; up_wreq = 1; up_waddr = 32'h000; up_wdata = 32'hFFFF_FFFF;
    step();
    up_rreq = 0; up_wreq = 0;
    rd(32'h000);
    check("r026_rd2", up_rdata, 32'hFFFF_BEEF);
    rd(32'hFFFF_F007);
    check("alias_tri", up_rdata, 32'h0000_FFFF);

    // interrupt path
    wr(32'h11C, 32'h8000_0000);
    wr(32'h128, 32'h0000_0001);
    wr(32'h004, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      gpio_io_i = gpio_io_i + 1;
      step();
    end
    rd(32'h120);
    check("r027_isr", up_rdata, 32'h1);
    check("r027_irq", {31'b0, irq}, 32'h1);
    rd(32'h11C);
    rd(32'h128);
    repeat (2) step();
    wr(32'h120, 32'h1);
    repeat (2) step();
    check("r027_irq_clr", {31'b0, irq}, 32'h0);
    gpio_io_i = gpio_io_i + 1;
    step();
    step();
    wr(32'h120, 32'h1);
    rd(32'h120);
    gpio_io_i = gpio_io_i ^ 32'h8000_0001;
    repeat (2) step();
    wr(32'h120, 32'h1);
    repeat (3) step();

    // channel-2 and unmapped space with continuous writes
    up_wreq = 1; up_rreq = 1;
    foreach (up_raddr[i]) begin end
    for (int i = 0; i < 6; i++) begin
      up_raddr = (i % 3 == 0) ? 32'h008 : (i % 3 == 1) ? 32'h00C : 32'h200;
      up_waddr = up_raddr;
      up_wdata = $urandom;
      step();
    end
    up_wreq = 0; up_rreq = 0;
    step();

    // random traffic
    for (int i = 0; i < 60; i++) begin
      logic [31:0] amap [8];
      amap = '{32'h000, 32'h004, 32'h008, 32'h11C, 32'h120, 32'h128, 32'h200, 32'h00C};
      up_rreq  = $urandom_range(0, 1);
      up_wreq  = $urandom_range(0, 3) == 0;
      up_raddr = amap[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      up_waddr = amap[$urandom_range(0, 7)];
      up_wdata = $urandom;
      if ($urandom_range(0, 2) == 0) gpio_io_i = $urandom;
      step();
    end
    up_rreq = 0; up_wreq = 0;
    step();

    // reset after configuration, with requests held
    wr(32'h004, 32'h0);
    wr(32'h000, 32'h5A5A_A5A5);
    rstn = 0; up_rreq = 1; up_wreq = 1;
    repeat (2) step();
    check("r029_t", gpio_io_t, 32'hFFFF_FFFF);
    check("r029_o", gpio_io_o, 32'h0);
    check("r029_irq", {31'b0, irq}, 32'h0);
    up_rreq = 0; up_wreq = 0; rstn = 1;
    repeat (2) step();
    check("sb_left", rd_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
